ss_error_integrator: RTL and testbench

- Receiving end of the cost stage's error output.
- Consumes the per-output stochastic error bitstreams (eps magnitude bits plus SIGN_L3 sign bits) and integrates them over a fixed window of clock cycles.
- Produces per-output signed binary error counts and a total absolute-error figure for weight-update scaling and convergence monitoring.
- Sits between the cost stage and the training controller; a valid/ready handshake hands results to the controller.

---
 rtl/ss_train_pkg.sv | 12 +
 rtl/ss_error_lane_counter.sv | 24 ++
 rtl/ss_error_integrator.sv | 111 +++++++++++
 tb/tb_ss_error_integrator.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ss_train_pkg.sv
// ss_train_pkg: shared FSM states, sign convention and count-width helper for the training error path.
package ss_train_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_ACCUM, ST_REPORT} state_t;

   localparam logic SIGN_NEG = 1'b1;

   function automatic int cw_of(input int window);
      return $clog2(window) + 2;
   endfunction

endpackage

// File: rtl/ss_error_lane_counter.sv
// ss_error_lane_counter: per-lane signed up/down error counter with sync clear and magnitude output.
module ss_error_lane_counter #(
   parameter int CW = 10
)(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clr_i,
   input  logic                 en_i,
   input  logic                 dn_i,
   output logic signed [CW-1:0] count_o,
   output logic        [CW-1:0] abs_o
);

   logic signed [CW-1:0] count_q;

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) count_q <= '0;
      else if (clr_i) count_q <= '0;
      else if (en_i) count_q <= dn_i ? count_q - CW'(1) : count_q + CW'(1);

   assign count_o = count_q;
   assign abs_o   = count_q[CW-1] ? -count_q : count_q;

endmodule

// File: rtl/ss_error_integrator.sv
// ss_error_integrator: integrates stochastic error bitstreams over a fixed window after an epoch-start
// settle period and hands signed per-lane counts plus their absolute sum to the training controller.
module ss_error_integrator import ss_train_pkg::*; #(
   parameter  int N      = 5,
   parameter  int WINDOW = 256,
   parameter  int SETTLE = 9,
   localparam int CW     = cw_of(WINDOW),
   localparam int AW     = CW + $clog2(N)
)(
   input  logic          CLK,
   input  logic          INIT,
   input  logic          CLK_TRAINING_flag,
   input  logic [N-1:0]  eps,
   input  logic [N-1:0]  SIGN_L3,
   input  logic          err_ready,
   output logic          err_valid,
   output logic [N*CW-1:0] err_count,
   output logic [AW-1:0] err_abs_sum,
   output logic          busy
);

   localparam int WW = $clog2(WINDOW);
   localparam int SW = SETTLE < 2 ? 1 : $clog2(SETTLE);
   localparam logic [SW-1:0] SLOAD = SW'(SETTLE > 0 ? SETTLE - 1 : 0);
   localparam state_t FIRST = SETTLE > 0 ? ST_SETTLE : ST_ACCUM;

   state_t          state_q;
   logic [SW-1:0]   scnt_q;
   logic [WW-1:0]   wcnt_q;
   logic            pend_q, valid_q, busy_q;
   logic [N*CW-1:0] cnt_all, abs_all, count_q;
   logic [AW-1:0]   sum_d, sum_q;
   logic            restart, clr;

   assign restart = CLK_TRAINING_flag && state_q != ST_REPORT;
   // accumulators run only in ACCUM; holding them clear elsewhere makes every new window start from zero
   assign clr     = CLK_TRAINING_flag || state_q != ST_ACCUM;

   for (genvar i = 0; i < N; i++) begin : g_lane
      ss_error_lane_counter #(.CW(CW)) u_cnt (
         .clk_i   (CLK),
         .rst_i   (INIT),
         .clr_i   (clr),
         .en_i    (state_q == ST_ACCUM && eps[i]),
         .dn_i    (SIGN_L3[i] == SIGN_NEG),
         .count_o (cnt_all[i*CW +: CW]),
         .abs_o   (abs_all[i*CW +: CW])
      );
   end

   always_comb begin
      sum_d = '0;
      for (int k = 0; k < N; k++) sum_d = sum_d + AW'(abs_all[k*CW +: CW]);
   end

   always_ff @(posedge CLK or posedge INIT)
      if (INIT) begin
         state_q <= ST_IDLE;
         scnt_q  <= '0;
         wcnt_q  <= '0;
         pend_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         count_q <= '0;
         sum_q   <= '0;
      end else if (restart) begin
         state_q <= FIRST;
         scnt_q  <= SLOAD;
         wcnt_q  <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_SETTLE:
               if (scnt_q == '0) begin
                  state_q <= ST_ACCUM;
                  wcnt_q  <= '0;
               end else scnt_q <= scnt_q - SW'(1);
            ST_ACCUM: begin
               wcnt_q <= wcnt_q + WW'(1);
               if (&wcnt_q) begin
                  state_q <= ST_REPORT;
                  busy_q  <= 1'b0;
               end
            end
            ST_REPORT:
               // first REPORT cycle captures the finished window; results are presented from the next one
               if (!valid_q) begin
                  valid_q <= 1'b1;
                  count_q <= cnt_all;
                  sum_q   <= sum_d;
                  pend_q  <= CLK_TRAINING_flag;
               end else if (err_ready) begin
                  valid_q <= 1'b0;
                  pend_q  <= 1'b0;
                  if (pend_q || CLK_TRAINING_flag) begin
                     state_q <= FIRST;
                     scnt_q  <= SLOAD;
                     wcnt_q  <= '0;
                     busy_q  <= 1'b1;
                  end else state_q <= ST_IDLE;
               end else if (CLK_TRAINING_flag) pend_q <= 1'b1;
            default: ;
         endcase
      end

   assign err_valid   = valid_q;
   assign busy        = busy_q;
   assign err_count   = count_q;
   assign err_abs_sum = sum_q;

endmodule

// File: tb/tb_ss_error_integrator.sv
// tb_ss_error_integrator: directed scenarios plus random traffic against an elapsed-time reference model.
module tb_ss_error_integrator;

   localparam int N      = 5;
   localparam int WINDOW = 256;
   localparam int SETTLE = 9;
   localparam int CW     = $clog2(WINDOW) + 2;
   localparam int AW     = CW + $clog2(N);

   logic CLK = 1'b0, INIT = 1'b1, CLK_TRAINING_flag = 1'b0, err_ready = 1'b0;
   logic [N-1:0] eps = '0, SIGN_L3 = '0;
   logic err_valid, busy;
   logic [N*CW-1:0] err_count;
   logic [AW-1:0] err_abs_sum;

   int n_chk = 0, n_err = 0;
   int fe = 0, lat = 0;

   always #5 CLK = ~CLK;

   ss_error_integrator #(.N(N), .WINDOW(WINDOW), .SETTLE(SETTLE)) dut (
      .CLK               (CLK),
      .INIT              (INIT),
      .CLK_TRAINING_flag (CLK_TRAINING_flag),
      .eps               (eps),
      .SIGN_L3           (SIGN_L3),
      .err_ready         (err_ready),
      .err_valid         (err_valid),
      .err_count         (err_count),
      .err_abs_sum       (err_abs_sum),
      .busy              (busy)
   );

   // reference model: a measurement is described by the edge it started on; samples count
   // only at elapsed edges SETTLE+1..SETTLE+WINDOW, the result appears one edge later
   int  edge_n = 0;
   bit  act = 0, rep = 0, pend = 0;
   int  s = 0;
   int  sums[N];
   int  res[N];
   int  res_abs = 0;

   task automatic mreset();
      act = 0; rep = 0; pend = 0; s = 0; res_abs = 0;
      for (int i = 0; i < N; i++) begin sums[i] = 0; res[i] = 0; end
   endtask

   task automatic mstart();
      act = 1; s = edge_n;
      for (int i = 0; i < N; i++) sums[i] = 0;
   endtask

   task automatic mstep();
      int d;
      d = edge_n - s;
      if (!act) begin
         if (CLK_TRAINING_flag) mstart();
      end else if (!rep && d <= SETTLE + WINDOW) begin
         if (CLK_TRAINING_flag) mstart();
         else if (d > SETTLE)
            for (int i = 0; i < N; i++) if (eps[i]) sums[i] += SIGN_L3[i] ? -1 : 1;
      end else if (!rep) begin
         rep = 1; res_abs = 0;
         for (int i = 0; i < N; i++) begin
            res[i] = sums[i];
            res_abs += sums[i] < 0 ? -sums[i] : sums[i];
         end
         pend = CLK_TRAINING_flag;
      end else if (err_ready) begin
         rep = 0;
         if (pend || CLK_TRAINING_flag) mstart(); else act = 0;
         pend = 0;
      end else if (CLK_TRAINING_flag) pend = 1;
   endtask

   initial mreset();

   always @(posedge CLK) begin
      edge_n++;
      if (INIT) mreset(); else mstep();
   end

   task automatic chk(input string nm, input longint act_v, input longint exp_v);
      n_chk++;
      if (act_v != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act_v, exp_v, edge_n);
      end
   endtask

   function automatic int lane(input int i);
      logic [CW-1:0] v;
      v = err_count[i*CW +: CW];
      return int'($signed(v));
   endfunction

   always @(negedge CLK) begin
      chk("err_valid", err_valid, rep);
      chk("busy", busy, act && !rep && (edge_n - s) < SETTLE + WINDOW);
      for (int i = 0; i < N; i++) chk($sformatf("err_count[%0d]", i), lane(i), res[i]);
      chk("err_abs_sum", err_abs_sum, res_abs);
   end

   task automatic start(input logic [N-1:0] e, input logic [N-1:0] sg);
      eps = e; SIGN_L3 = sg; CLK_TRAINING_flag = 1'b1; fe = edge_n + 1;
      @(negedge CLK);
      CLK_TRAINING_flag = 1'b0;
   endtask

   task automatic wait_valid(input bit tog);
      int n = 0;
      while (!err_valid && n < 400) begin
         if (tog) eps[2] = ~eps[2];
         @(negedge CLK);
         n++;
      end
      chk("valid_within_bound", err_valid, 1);
      lat = edge_n - fe + 1;
   endtask

   task automatic accept();
      err_ready = 1'b1;
      @(negedge CLK);
      err_ready = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge CLK);
      chk("reset_valid", err_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_abs", err_abs_sum, 0);
      chk("reset_lane0", lane(0), 0);
      INIT = 1'b0;
      repeat (2) @(negedge CLK);

      start('1, '0);
      wait_valid(0);
      chk("lat_pos", lat, 267);
      for (int i = 0; i < N; i++) chk($sformatf("pos_lane%0d", i), lane(i), 256);
      chk("pos_abs", err_abs_sum, 1280);
      accept();
      repeat (2) @(negedge CLK);

      start('1, '1);
      wait_valid(1);
      chk("neg_lane2", lane(2), -128);
      chk("neg_lane0", lane(0), -256);
      chk("neg_lane4", lane(4), -256);
      chk("neg_abs", err_abs_sum, 1152);
      accept();

      start('1, '0);
      repeat (SETTLE) @(negedge CLK);
      eps = '0;
      wait_valid(0);
      chk("settle_lane0", lane(0), 0);
      chk("settle_lane3", lane(3), 0);
      chk("settle_abs", err_abs_sum, 0);
      accept();

      start('1, '0);
      repeat (SETTLE + 100) @(negedge CLK);
      CLK_TRAINING_flag = 1'b1; fe = edge_n + 1;
      @(negedge CLK);
      CLK_TRAINING_flag = 1'b0;
      wait_valid(0);
      chk("restart_lat", lat, 267);
      chk("restart_lane1", lane(1), 256);
      chk("restart_abs", err_abs_sum, 1280);
      accept();

      start('1, '0);
      wait_valid(0);
      for (int c = 0; c < 20; c++) begin
         CLK_TRAINING_flag = (c == 5);
         @(negedge CLK);
      end
      CLK_TRAINING_flag = 1'b0;
      chk("hold_valid", err_valid, 1);
      chk("hold_lane0", lane(0), 256);
      chk("hold_abs", err_abs_sum, 1280);
      accept();
      chk("pend_valid", err_valid, 0);
      chk("pend_busy", busy, 1);

      repeat (40) @(negedge CLK);
      @(posedge CLK);
      #3 INIT = 1'b1;
      #1;
      chk("init_valid", err_valid, 0);
      chk("init_busy", busy, 0);
      chk("init_abs", err_abs_sum, 0);
      chk("init_lane4", lane(4), 0);
      mreset();
      @(negedge CLK);
      INIT = 1'b0;
      @(negedge CLK);

      start('1, 5'b01010);
      wait_valid(0);
      chk("post_init_lat", lat, 267);
      chk("post_init_lane0", lane(0), 256);
      chk("post_init_lane1", lane(1), -256);
      chk("post_init_abs", err_abs_sum, 1280);
      accept();

      for (int c = 0; c < 3000; c++) begin
         eps = N'($urandom);
         SIGN_L3 = N'($urandom);
         err_ready = ($urandom_range(3) == 0);
         CLK_TRAINING_flag = (c == 0) || ($urandom_range(399) == 0);
         @(negedge CLK);
      end
      CLK_TRAINING_flag = 1'b0;
      err_ready = 1'b1;
      repeat (2) @(negedge CLK);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
